sdr_16_port_arb: RTL and testbench
==================================

// Module: sdr_16_port_arb
// PURPOSE
//  Shares the 16-bit SDR SDRAM command FSM between NP ingress FIFO ports with round-robin grants.
//  Generates the periodic auto-refresh request and tracks postponed refreshes.
//  Sits between the per-port wishbone ingress FIFOs and the SDR command FSM.
//  Drives the FSM's fifo_empty/refresh_req inputs; observes its state_idle/cmd_aref outputs.
// PARAMETERS
//  nr_of_ports   4    number of requesting ports NP, 2..8
//  ref_interval  390  sdram_clk cycles between refresh ticks (7.8us @ 50MHz)
//  ref_max_pend  8    max outstanding (postponed) refreshes, 1..15
// PORTS
//  sdram_clk     in   1    clock
//  sdram_rst     in   1    reset; asynchronous, active-high
//  port_empty    in   NP   per-port ingress FIFO empty flags, bit i = port i
//  state_idle    in   1    FSM is in idle
//  cmd_aref      in   1    FSM issued an auto-refresh command this cycle (1-cycle pulse)
//  fifo_sel      out  NP   one-hot grant; selects address/data FIFO feeding the FSM
//  fifo_sel_enc  out  3    binary index of fifo_sel
//  fifo_empty    out  1    empty flag presented to FSM for the granted port
//  refresh_req   out  1    high while pend_cnt != 0
//  ref_overflow  out  1    sticky: a tick arrived with pend_cnt == ref_max_pend
// BEHAVIOUR
//  Reset: fifo_sel = 1 (port 0), fifo_sel_enc = 0, fifo_empty = 1, refresh_req = 0.
//   Also at reset: ref_overflow = 0, ref_cnt = 0, pend_cnt = 0, served = 0.
//  Reset mid-operation: all of the above apply immediately (async); no grant or refresh state survives.
//  Refresh timer: ref_cnt counts 0..ref_interval-1 and wraps; tick = (ref_cnt == ref_interval-1).
//   Timer free-runs from reset, including during FSM init.
//  pend_cnt update per cycle:
//   - tick & !cmd_aref: +1, saturating at ref_max_pend. Saturated tick sets ref_overflow (until reset).
//   - cmd_aref & !tick: -1, saturating at 0. FSM init refresh pulses at pend_cnt == 0 are no-ops.
//   - tick & cmd_aref: unchanged.
//   - refresh_req = (pend_cnt != 0), registered.
//  Grant register gnt (one-hot) plus served flag:
//   - take = state_idle & !refresh_req & !fifo_empty. FSM leaves idle for adr on this edge.
//   - On take: served <= 1, gnt held.
//   - While !state_idle: gnt held, served held. The grant is never changed during a transaction.
//   - state_idle & served: rotate. gnt <= first non-empty port searching gnt+1, gnt+2, ... wrapping.
//     The current port is searched last. If none is non-empty, gnt unchanged. served <= 0.
//   - state_idle & !served & port_empty[gnt]: rotate as above (idle-hunting).
//   - state_idle & !served & !port_empty[gnt]: hold.
//  fifo_empty = port_empty[gnt] | (state_idle & served), combinational from registers and inputs.
//   This gives a 1-cycle bubble after every transaction so the rotated grant is seen before the next take.
//  Refresh has priority: with refresh_req=1 the FSM takes rfr regardless of fifo_empty. Grant may still rotate meanwhile.
//  port_empty[gnt] rising mid-transaction (write burst waiting for data) passes straight through; grant held.
//  Latency: request on idle bus to FSM-visible fifo_empty=0:
//   - 0 cycles if the port is already granted;
//   - else 1 cycle after the rotate edge.
//  fifo_sel_enc = encode(gnt); fifo_sel = gnt.
// STRUCTURE
//  Shared package sdr_16_pkg: cmd_* encodings, bte encodings, ref_interval/ref_max_pend defaults.
//  Sub-module sdr_rr_pick: combinational round-robin picker.
//   Inputs: req[NP], ptr one-hot. Outputs: one-hot pick, any.
//   Search starts at ptr rotated by one.
//  Timer, pend_cnt and grant registers live in the top.
// TESTING
//  1 Reset, all ports empty, 1000 cycles, ref_interval=390, no cmd_aref:
//    -> refresh_req rises in the cycle after ref_cnt hits 389; pend_cnt = 2 at cycle 781.
//  2 Ports 0,2,3 continuously non-empty; FSM model does 10-cycle transactions, no refresh:
//    -> grant order 0,2,3,0,2,3; fifo_empty=1 for exactly one idle cycle between transactions.
//  3 Only port 1 non-empty, others empty:
//    -> back-to-back grants to port 1; fifo_sel=4'b0010; fifo_sel_enc=1.
//  4 tick and cmd_aref in the same cycle with pend_cnt=1 -> pend_cnt stays 1, refresh_req stays 1.
//  5 No cmd_aref for 9 ticks, ref_max_pend=8 -> pend_cnt=8, ref_overflow=1 from the 9th tick onward.
//  6 Assert sdram_rst mid-transaction with gnt=port 2 and pend_cnt=3:
//    -> fifo_sel=port 0, refresh_req=0, fifo_empty=1 immediately.
//    -> after release, normal arbitration resumes.

Source files
------------

// File: rtl/sdr_16_pkg.sv
// Shared definitions for the 16-bit SDR SDRAM controller: command and burst
// encodings, refresh defaults and a one-hot to binary helper.
package sdr_16_pkg;

    // SDRAM command encoding as {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CMD_INHIBIT = 4'b1111,
        CMD_NOP     = 4'b0111,
        CMD_ACT     = 4'b0011,
        CMD_READ    = 4'b0101,
        CMD_WRITE   = 4'b0100,
        CMD_PRE     = 4'b0010,
        CMD_AREF    = 4'b0001,
        CMD_LMR     = 4'b0000
    } sdr_cmd_e;

    // Wishbone burst type extension
    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_e;

    // 7.8us refresh period at 50MHz, and the JEDEC limit on postponed refreshes
    localparam int REF_INTERVAL_DEF = 390;
    localparam int REF_MAX_PEND_DEF = 8;

    // Binary index of a one-hot vector of up to 8 bits
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sdr_rr_pick.sv
// Combinational round-robin picker: returns the first requester found when
// searching upward from the position just after the one-hot pointer, wrapping
// around, with the pointer position itself examined last.
module sdr_rr_pick
    import sdr_16_pkg::*;
#(
    parameter int np = 4
) (
    input  logic [np-1:0] req,
    input  logic [np-1:0] ptr,
    output logic [np-1:0] pick,
    output logic          any
);

    int base;
    int idx;

    // Scan np positions starting one past the pointer; first hit wins
    always_comb begin
        pick = '0;
        any  = 1'b0;
        base = 0;
        idx  = 0;
        for (int i = 0; i < np; i++) begin
            if (ptr[i]) begin
                base = i;
            end
        end
        for (int k = 1; k <= np; k++) begin
            idx = (base + k) % np;
            if (!any && req[idx]) begin
                pick[idx] = 1'b1;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdr_16_port_arb.sv
// Round-robin arbiter sharing the SDR command FSM between the ingress FIFO
// ports, plus the periodic auto-refresh timer and postponed-refresh counter.
module sdr_16_port_arb
    import sdr_16_pkg::*;
#(
    parameter int nr_of_ports  = 4,
    parameter int ref_interval = REF_INTERVAL_DEF,
    parameter int ref_max_pend = REF_MAX_PEND_DEF
) (
    input  logic                   sdram_clk,
    input  logic                   sdram_rst,
    input  logic [nr_of_ports-1:0] port_empty,
    input  logic                   state_idle,
    input  logic                   cmd_aref,
    output logic [nr_of_ports-1:0] fifo_sel,
    output logic [2:0]             fifo_sel_enc,
    output logic                   fifo_empty,
    output logic                   refresh_req,
    output logic                   ref_overflow
);

    localparam int RCW = (ref_interval > 1) ? $clog2(ref_interval) : 1;
    localparam logic [RCW-1:0] REF_LAST = RCW'(ref_interval - 1);
    localparam logic [3:0]     PEND_MAX = 4'(ref_max_pend);

    logic [RCW-1:0]         ref_cnt;
    logic                   tick;
    logic [3:0]             pend_cnt;
    logic [3:0]             pend_next;
    logic                   ovf_set;
    logic [nr_of_ports-1:0] gnt;
    logic                   served;
    logic                   gnt_empty;
    logic                   rotate;
    logic                   take;
    logic [nr_of_ports-1:0] pick;
    logic                   pick_any;

    assign tick      = (ref_cnt == REF_LAST);
    assign gnt_empty = |(port_empty & gnt);

    // The bubble term hides the old port for one idle cycle after a
    // transaction so the FSM sees the rotated grant before its next take.
    // Reset forces empty so the FSM cannot start on a half-reset arbiter.
    assign fifo_empty = sdram_rst | gnt_empty | (state_idle & served);

    assign take   = state_idle & ~refresh_req & ~fifo_empty;
    assign rotate = state_idle & (served | gnt_empty);

    assign fifo_sel     = gnt;
    assign fifo_sel_enc = onehot_to_idx(8'(gnt));

    sdr_rr_pick #(
        .np  (nr_of_ports)
    ) u_pick (
        .req (~port_empty),
        .ptr (gnt),
        .pick(pick),
        .any (pick_any)
    );

    // Refresh timer free-runs from reset, wrapping every ref_interval cycles
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            ref_cnt <= '0;
        end else if (tick) begin
            ref_cnt <= '0;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // Next postponed-refresh count; a tick and a refresh in the same cycle cancel
    always_comb begin
        pend_next = pend_cnt;
        ovf_set   = 1'b0;
        if (tick && !cmd_aref) begin
            if (pend_cnt == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pend_next = pend_cnt + 1'b1;
            end
        end else if (cmd_aref && !tick && pend_cnt != 4'd0) begin
            pend_next = pend_cnt - 1'b1;
        end
    end

    // Pending counter with registered request and sticky overflow
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            pend_cnt     <= '0;
            refresh_req  <= 1'b0;
            ref_overflow <= 1'b0;
        end else begin
            pend_cnt    <= pend_next;
            refresh_req <= (pend_next != 4'd0);
            if (ovf_set) begin
                ref_overflow <= 1'b1;
            end
        end
    end

    // Grant only moves while the FSM is idle and the current port is done or empty
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            gnt    <= nr_of_ports'(1);
            served <= 1'b0;
        end else if (take) begin
            served <= 1'b1;
        end else if (rotate) begin
            if (pick_any) begin
                gnt <= pick;
            end
            served <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdr_16_port_arb.sv
// Self-checking bench for sdr_16_port_arb: a per-cycle reference model built
// from the arbitration and refresh rules feeds a scoreboard that a separate
// monitor drains on the falling clock edge.
module tb_sdr_16_port_arb;

    localparam int NP   = 4;
    localparam int REF  = 390;
    localparam int MAXP = 8;

    typedef struct {
        int enc;
        bit fe;
        bit rr;
        bit ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] port_empty = '1;
    logic          state_idle = 1'b1;
    logic          cmd_aref = 1'b0;
    logic [NP-1:0] fifo_sel;
    logic [2:0]    fifo_sel_enc;
    logic          fifo_empty;
    logic          refresh_req;
    logic          ref_overflow;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   take_log[$];

    int m_ref, m_pend, m_gnt;
    bit m_ovf, m_served;
    int env_busy;
    bit env_aref;

    sdr_16_port_arb #(
        .nr_of_ports (NP),
        .ref_interval(REF),
        .ref_max_pend(MAXP)
    ) dut (
        .sdram_clk   (clk),
        .sdram_rst   (rst),
        .port_empty  (port_empty),
        .state_idle  (state_idle),
        .cmd_aref    (cmd_aref),
        .fifo_sel    (fifo_sel),
        .fifo_sel_enc(fifo_sel_enc),
        .fifo_empty  (fifo_empty),
        .refresh_req (refresh_req),
        .ref_overflow(ref_overflow)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Watchdog so a stuck run still ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle, push the expected outputs, then advance the model across the edge
    task automatic applyStimulus(input logic [NP-1:0] empty, input logic idle, input logic aref);
        exp_t e;
        bit   fe, rr, take, tick;
        port_empty = empty;
        state_idle = idle;
        cmd_aref   = aref;
        fe    = empty[m_gnt] || (idle && m_served);
        rr    = (m_pend != 0);
        e.enc = m_gnt;
        e.fe  = fe;
        e.rr  = rr;
        e.ovf = m_ovf;
        sb.push_back(e);
        take = idle && !rr && !fe;
        @(posedge clk);
        tick = (m_ref == REF - 1);
        if (tick && !aref) begin
            if (m_pend == MAXP) m_ovf = 1;
            else m_pend++;
        end else if (aref && !tick && m_pend > 0) begin
            m_pend--;
        end
        m_ref = (m_ref + 1) % REF;
        if (take) begin
            m_served = 1;
        end else if (idle && (m_served || empty[m_gnt])) begin
            for (int k = 1; k <= NP; k++) begin
                if (!empty[(m_gnt + k) % NP]) begin
                    m_gnt = (m_gnt + k) % NP;
                    break;
                end
            end
            m_served = 0;
        end
        #1;
    endtask

    // Behavioural FSM: takes a port when allowed, refreshes when requested
    task automatic runFsm(input int n, input logic [NP-1:0] mask, input bit rand_empty,
                          input bit allow_ref, input int fixed_len);
        logic [NP-1:0] cur;
        bit idle, aref, fe, rr;
        cur = mask;
        for (int c = 0; c < n; c++) begin
            if (rand_empty && $urandom_range(0, 3) == 0) cur = NP'($urandom);
            idle = (env_busy == 0);
            aref = env_aref;
            fe   = cur[m_gnt] || (idle && m_served);
            rr   = (m_pend != 0);
            env_aref = 0;
            if (idle && !rr && !fe) take_log.push_back(int'(fifo_sel_enc));
            applyStimulus(cur, idle, aref);
            if (env_busy > 0) begin
                env_busy--;
            end else if (allow_ref && rr) begin
                env_busy = 4;
                env_aref = 1;
            end else if (!rr && !fe) begin
                env_busy = (fixed_len > 0) ? fixed_len : int'($urandom_range(2, 9));
            end
        end
    endtask

    // Assert reset between edges, check outputs react at once, then release
    task automatic resetDut();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_fifo_sel", int'(fifo_sel), 1);
        checkOutput("rst_fifo_sel_enc", int'(fifo_sel_enc), 0);
        checkOutput("rst_fifo_empty", int'(fifo_empty), 1);
        checkOutput("rst_refresh_req", int'(refresh_req), 0);
        checkOutput("rst_ref_overflow", int'(ref_overflow), 0);
        m_ref = 0; m_pend = 0; m_gnt = 0; m_ovf = 0; m_served = 0;
        env_busy = 0; env_aref = 0;
        take_log.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare every registered expectation on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("fifo_sel_enc", int'(fifo_sel_enc), e.enc);
                checkOutput("fifo_sel", int'(fifo_sel), 1 << e.enc);
                checkOutput("fifo_empty", int'(fifo_empty), int'(e.fe));
                checkOutput("refresh_req", int'(refresh_req), int'(e.rr));
                checkOutput("ref_overflow", int'(ref_overflow), int'(e.ovf));
            end
        end
    end

    // Directed scenarios followed by a randomized run
    initial begin
        int exp_order[6] = '{0, 2, 3, 0, 2, 3};
        int guard;
        resetDut();

        $display("[TB] idle bus, refresh timer and overflow");
        repeat (3600) applyStimulus('1, 1'b1, 1'b0);
        checkOutput("t5_overflow", int'(ref_overflow), 1);
        checkOutput("t5_refresh_req", int'(refresh_req), 1);

        $display("[TB] ports 0,2,3 busy, 10-cycle transactions");
        resetDut();
        runFsm(80, 4'b0010, 1'b0, 1'b0, 10);
        for (int i = 0; i < 6; i++) begin
            checkOutput("t2_order", (i < take_log.size()) ? take_log[i] : -1, exp_order[i]);
        end

        $display("[TB] only port 1 busy");
        resetDut();
        runFsm(120, 4'b1101, 1'b0, 1'b1, 0);
        checkOutput("t3_has_takes", int'(take_log.size() > 3), 1);
        foreach (take_log[i]) checkOutput("t3_port1", take_log[i], 1);

        $display("[TB] tick coinciding with refresh");
        resetDut();
        repeat (390) applyStimulus('1, 1'b1, 1'b0);
        guard = 0;
        while (m_ref != REF - 1 && guard < 2 * REF) begin
            applyStimulus('1, 1'b1, 1'b0);
            guard++;
        end
        applyStimulus('1, 1'b0, 1'b1);
        repeat (3) applyStimulus('1, 1'b0, 1'b0);
        checkOutput("t4_refresh_held", int'(refresh_req), 1);
        applyStimulus('1, 1'b0, 1'b1);
        repeat (2) applyStimulus('1, 1'b1, 1'b0);
        checkOutput("t4_refresh_cleared", int'(refresh_req), 0);

        $display("[TB] reset mid-transaction on port 2");
        resetDut();
        applyStimulus(4'b1011, 1'b1, 1'b0);
        applyStimulus(4'b1011, 1'b1, 1'b0);
        guard = 0;
        while (m_pend < 3 && guard < 4 * REF) begin
            applyStimulus(4'b1011, 1'b0, 1'b0);
            guard++;
        end
        repeat (2) applyStimulus(4'b1011, 1'b0, 1'b0);
        checkOutput("t6_gnt_before", int'(fifo_sel_enc), 2);
        checkOutput("t6_rr_before", int'(refresh_req), 1);
        resetDut();

        $display("[TB] randomized arbitration with refresh");
        runFsm(3000, '0, 1'b1, 1'b1, 0);

        @(negedge clk);
        #1;
        checkOutput("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
